// File: rtl/spatial_sram_server.sv
// spatial_sram_server
//   Serves item-memory (IM), projM_neg and projM_pos rows to the spatial
//   encoder. The three banks share one single-port access per cycle and are
//   always read together at one address.
//
//   Read handshake (one rule for the whole block):
//     The encoder holds Req_SI high with Addr_DI.
//     Valid_SO is high exactly when a valid buffer holds Addr_DI. Only in
//     that cycle do IM_DO/ProjNeg_DO/ProjPos_DO carry that row. Otherwise
//     the row outputs are all-zero.
//     A row is consumed when Valid_SO and Adv_SI are high in the same cycle.
//     Ready_SO is low only while a host write owns the port.
//
//   Optional feature: define SPATIAL_SRAM_PREFETCH_EN to add a prefetch
//   buffer. It streams sequential addresses at one row per cycle.
//   Without this macro, a sequential stream runs at one row per two cycles.
//
//   Ports
//     Clk_CI, Reset_RI      clock; asynchronous active-high reset
//     Req_SI, Adv_SI        encoder request / consume-current-row
//     Addr_DI               requested row
//     IM_DO, ProjNeg_DO,    row data, zero unless Valid_SO
//     ProjPos_DO
//     Valid_SO, Ready_SO    row valid / port not taken by a write
//     WrEn_SI, WrSel_SI,    host write: strobe, bank (0 IM, 1 neg, 2 pos,
//     WrAddr_DI, WrData_DI  3 ignored), row, data

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif
`ifndef INPUT_CHANNELS
`define INPUT_CHANNELS 48
`endif
`ifndef ceilLog2
`define ceilLog2(x) ($clog2(x))
`endif

module spatial_sram_server #(
    parameter int DEPTH = `INPUT_CHANNELS,
    parameter int AW    = `ceilLog2(`INPUT_CHANNELS)
) (
    input  logic                     Clk_CI,
    input  logic                     Reset_RI,
    input  logic                     Req_SI,
    input  logic                     Adv_SI,
    input  logic [AW-1:0]            Addr_DI,
    output logic [`HV_DIMENSION-1:0] IM_DO,
    output logic [`HV_DIMENSION-1:0] ProjNeg_DO,
    output logic [`HV_DIMENSION-1:0] ProjPos_DO,
    output logic                     Valid_SO,
    output logic                     Ready_SO,
    input  logic                     WrEn_SI,
    input  logic [1:0]               WrSel_SI,
    input  logic [AW-1:0]            WrAddr_DI,
    input  logic [`HV_DIMENSION-1:0] WrData_DI
);
    localparam int HV = `HV_DIMENSION;
    typedef logic [AW-1:0] addr_t;
    typedef logic [HV-1:0] row_t;

    function automatic logic in_range(input addr_t a);
        return (int'(a) < DEPTH);
    endfunction

    row_t im_mem  [DEPTH];
    row_t neg_mem [DEPTH];
    row_t pos_mem [DEPTH];

    addr_t pri_addr, pri_addr_d;
    logic  pri_vld, pri_vld_d;
    row_t  pri_im, pri_neg, pri_pos;
    logic  hit_pri, hit;

    // Shared port: one row triple is read per cycle at rd_addr.
    addr_t rd_addr;
    logic  rd_pri;
    row_t  rd_im, rd_neg, rd_pos;

    assign hit_pri  = pri_vld && (pri_addr == Addr_DI);
    assign Valid_SO = Req_SI && hit;
    assign Ready_SO = ~WrEn_SI;

`ifdef SPATIAL_SRAM_PREFETCH_EN
    addr_t pf_addr, pf_addr_d, next_addr;
    logic  pf_vld, pf_vld_d, hit_pf, rd_pf, copy_pf;
    row_t  pf_im, pf_neg, pf_pos;

    assign hit_pf    = pf_vld && (pf_addr == Addr_DI);
    assign hit       = hit_pri || hit_pf;
    assign next_addr = (int'(Addr_DI) == DEPTH - 1) ? '0 : Addr_DI + addr_t'(1);
    // A prefetch-only hit promotes the prefetched row to primary. The copy
    // does not use the port, so it proceeds even while a write is in progress.
    assign copy_pf   = Req_SI && hit_pf && !hit_pri;
`else
    logic unused_adv;
    assign hit        = hit_pri;
    assign unused_adv = Adv_SI;
`endif

    // Arbitration. A write has priority, then a miss read, then a prefetch.
    // A blocked miss read retries automatically while the miss persists.
    always_comb begin
        rd_pri  = 1'b0;
        rd_addr = Addr_DI;
`ifdef SPATIAL_SRAM_PREFETCH_EN
        rd_pf   = 1'b0;
`endif
        if (!WrEn_SI) begin
            if (Req_SI && !hit) begin
                rd_pri = 1'b1;
`ifdef SPATIAL_SRAM_PREFETCH_EN
            end else if (Valid_SO && Adv_SI) begin
                rd_pf   = 1'b1;
                rd_addr = next_addr;
`endif
            end
        end
    end

    // Out-of-range rows read as zero.
    always_comb begin
        rd_im  = '0;
        rd_neg = '0;
        rd_pos = '0;
        if (in_range(rd_addr)) begin
            rd_im  = im_mem[rd_addr];
            rd_neg = neg_mem[rd_addr];
            rd_pos = pos_mem[rd_addr];
        end
    end

    // The buffer's next address is compared with the write address. A row
    // being written therefore never ends up valid with its old contents.
    always_comb begin
        pri_addr_d = pri_addr;
        pri_vld_d  = pri_vld;
        if (rd_pri) begin
            pri_addr_d = Addr_DI;
            pri_vld_d  = 1'b1;
`ifdef SPATIAL_SRAM_PREFETCH_EN
        end else if (copy_pf) begin
            pri_addr_d = pf_addr;
            pri_vld_d  = 1'b1;
`endif
        end
        if (WrEn_SI && (pri_addr_d == WrAddr_DI)) pri_vld_d = 1'b0;
    end

`ifdef SPATIAL_SRAM_PREFETCH_EN
    always_comb begin
        pf_addr_d = pf_addr;
        pf_vld_d  = pf_vld;
        if (rd_pf) begin
            pf_addr_d = next_addr;
            pf_vld_d  = 1'b1;
        end
        if (WrEn_SI && (pf_addr_d == WrAddr_DI)) pf_vld_d = 1'b0;
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            pf_vld  <= 1'b0;
            pf_addr <= '0;
        end else begin
            pf_vld  <= pf_vld_d;
            pf_addr <= pf_addr_d;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (rd_pf) begin
            pf_im  <= rd_im;
            pf_neg <= rd_neg;
            pf_pos <= rd_pos;
        end
    end
`endif

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            pri_vld  <= 1'b0;
            pri_addr <= '0;
        end else begin
            pri_vld  <= pri_vld_d;
            pri_addr <= pri_addr_d;
        end
    end

    // Data holding registers need no reset. The valid flags gate their use.
    always_ff @(posedge Clk_CI) begin
        if (rd_pri) begin
            pri_im  <= rd_im;
            pri_neg <= rd_neg;
            pri_pos <= rd_pos;
`ifdef SPATIAL_SRAM_PREFETCH_EN
        end else if (copy_pf) begin
            pri_im  <= pf_im;
            pri_neg <= pf_neg;
            pri_pos <= pf_pos;
`endif
        end
    end

    // Bank writes. Reset leaves the contents alone, and out-of-range rows
    // are dropped.
    always_ff @(posedge Clk_CI) begin
        if (WrEn_SI && in_range(WrAddr_DI)) begin
            case (WrSel_SI)
                2'd0:    im_mem[WrAddr_DI]  <= WrData_DI;
                2'd1:    neg_mem[WrAddr_DI] <= WrData_DI;
                2'd2:    pos_mem[WrAddr_DI] <= WrData_DI;
                default: ;
            endcase
        end
    end

    always_comb begin
        IM_DO      = '0;
        ProjNeg_DO = '0;
        ProjPos_DO = '0;
        if (Req_SI && hit_pri) begin
            IM_DO      = pri_im;
            ProjNeg_DO = pri_neg;
            ProjPos_DO = pri_pos;
`ifdef SPATIAL_SRAM_PREFETCH_EN
        end else if (Req_SI && hit_pf) begin
            IM_DO      = pf_im;
            ProjNeg_DO = pf_neg;
            ProjPos_DO = pf_pos;
`endif
        end
    end

endmodule

// File: tb/tb_spatial_sram_server.sv
// Testbench for spatial_sram_server.
// Rows are modelled as plain arrays. The testbench tracks which addresses are
// currently servable and always expects the current array contents for them.

`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif
`ifndef INPUT_CHANNELS
`define INPUT_CHANNELS 48
`endif
`ifndef ceilLog2
`define ceilLog2(x) ($clog2(x))
`endif

module tb_spatial_sram_server;
    localparam int HV    = `HV_DIMENSION;
    localparam int DEPTH = `INPUT_CHANNELS;
    localparam int AW    = `ceilLog2(`INPUT_CHANNELS);
`ifdef SPATIAL_SRAM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    typedef logic [HV-1:0] row_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk_ci = 1'b0;
    logic          reset_ri;
    logic          req_si, adv_si, wren_si;
    logic [AW-1:0] addr_di, wraddr_di;
    logic [1:0]    wrsel_si;
    row_t          wrdata_di, im_do, neg_do, pos_do;
    logic          valid_so, ready_so;

    always #5 clk_ci = ~clk_ci;

    spatial_sram_server #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk_CI(clk_ci), .Reset_RI(reset_ri),
        .Req_SI(req_si), .Adv_SI(adv_si), .Addr_DI(addr_di),
        .IM_DO(im_do), .ProjNeg_DO(neg_do), .ProjPos_DO(pos_do),
        .Valid_SO(valid_so), .Ready_SO(ready_so),
        .WrEn_SI(wren_si), .WrSel_SI(wrsel_si),
        .WrAddr_DI(wraddr_di), .WrData_DI(wrdata_di)
    );

    // ---------------- reference model ----------------
    row_t m_im [DEPTH];
    row_t m_neg[DEPTH];
    row_t m_pos[DEPTH];
    int   held_a = -1;   // address held for the encoder, -1 = none
    int   ahead_a = -1;  // address fetched ahead of the stream, -1 = none

    function automatic row_t bank_row(input int bank, input int a);
        if (a >= DEPTH) return '0;
        case (bank)
            0:       return m_im[a];
            1:       return m_neg[a];
            default: return m_pos[a];
        endcase
    endfunction

    function automatic row_t rnd_row();
        row_t r = '0;
        for (int i = 0; i < HV; i += 32) r = (r << 32) | row_t'($urandom);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int   n_pass = 0, n_fail = 0, n_total = 0;
    logic obs_v, obs_rdy;
    row_t obs_im, obs_neg, obs_pos;

    task automatic chk(input string tag, input row_t obs, input row_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check at negedge against the model, then
    // advance the model at the posedge.
    task automatic step(input logic req, input logic adv, input int addr,
                        input logic wen, input logic [1:0] wsel,
                        input int waddr, input row_t wdata);
        logic h_held, h_ahead, h;
        req_si = req; adv_si = adv; addr_di = AW'(addr);
        wren_si = wen; wrsel_si = wsel; wraddr_di = AW'(waddr); wrdata_di = wdata;
        @(negedge clk_ci);
        h_held  = req && (held_a == addr);
        h_ahead = req && (ahead_a == addr);
        h       = h_held || h_ahead;
        obs_v = valid_so; obs_rdy = ready_so;
        obs_im = im_do; obs_neg = neg_do; obs_pos = pos_do;
        chk("valid", row_t'(valid_so), row_t'(h));
        chk("ready", row_t'(ready_so), row_t'(!wen));
        chk("im",  im_do,  h ? bank_row(0, addr) : '0);
        chk("neg", neg_do, h ? bank_row(1, addr) : '0);
        chk("pos", pos_do, h ? bank_row(2, addr) : '0);
        @(posedge clk_ci);
        if (h_ahead && !h_held) held_a = addr;
        if (wen) begin
            if (waddr < DEPTH) begin
                case (wsel)
                    2'd0: m_im[waddr]  = wdata;
                    2'd1: m_neg[waddr] = wdata;
                    2'd2: m_pos[waddr] = wdata;
                    default: ;
                endcase
            end
            if (held_a == waddr)  held_a = -1;
            if (ahead_a == waddr) ahead_a = -1;
        end else if (req && !h) begin
            held_a = addr;
        end else if (PF && h && adv) begin
            ahead_a = (addr == DEPTH - 1) ? 0 : addr + 1;
        end
        #1;
    endtask

    task automatic rd(input logic req, input logic adv, input int addr);
        step(req, adv, addr, 1'b0, 2'd0, 0, '0);
    endtask

    task automatic wr(input logic [1:0] sel, input int waddr, input row_t data);
        step(1'b0, 1'b0, 0, 1'b1, sel, waddr, data);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        row_t a_row, b_row, c_row, d_row;
        int   clocks, sa;
        reset_ri = 1'b1; req_si = 1'b0; adv_si = 1'b0; addr_di = '0;
        wren_si = 1'b0; wrsel_si = 2'd0; wraddr_di = '0; wrdata_di = '0;

        // reset state
        #2;
        chk("rst_valid", row_t'(valid_so), '0);
        chk("rst_ready", row_t'(ready_so), row_t'(1));
        chk("rst_im", im_do, '0);
        repeat (2) @(posedge clk_ci);
        #1 reset_ri = 1'b0;

        // fill every bank
        for (int a = 0; a < DEPTH; a++)
            for (int s = 0; s < 3; s++) wr(2'(s), a, rnd_row());

        // basic read of row 3 after writing A/B/C
        a_row = rnd_row(); b_row = rnd_row(); c_row = rnd_row();
        wr(2'd0, 3, a_row); wr(2'd1, 3, b_row); wr(2'd2, 3, c_row);
        rd(1'b1, 1'b0, 3);
        chk("basic_miss", row_t'(obs_v), '0);
        rd(1'b1, 1'b0, 3);
        chk("basic_hit", row_t'(obs_v), row_t'(1));
        chk("basic_A", obs_im, a_row);
        chk("basic_B", obs_neg, b_row);
        chk("basic_C", obs_pos, c_row);

        // sequential stream 0..31
        clocks = 0; sa = 0;
        while (sa < 32 && clocks < 200) begin
            rd(1'b1, 1'b1, sa);
            clocks++;
            if (obs_v) sa++;
        end
        chk("stream_clocks", row_t'(clocks), PF ? row_t'(33) : row_t'(64));

        // write blocks a miss read, then write to the held row
        step(1'b1, 1'b0, 7, 1'b1, 2'd1, 9, rnd_row());
        chk("wmiss_ready", row_t'(obs_rdy), '0);
        chk("wmiss_v0", row_t'(obs_v), '0);
        rd(1'b1, 1'b0, 7);
        chk("wmiss_v1", row_t'(obs_v), '0);
        rd(1'b1, 1'b0, 7);
        chk("wmiss_v2", row_t'(obs_v), row_t'(1));
        d_row = rnd_row();
        step(1'b1, 1'b0, 7, 1'b1, 2'd0, 7, d_row);
        chk("whold_v_same", row_t'(obs_v), row_t'(1));
        rd(1'b1, 1'b0, 7);
        chk("whold_drop", row_t'(obs_v), '0);
        rd(1'b1, 1'b0, 7);
        chk("whold_new_v", row_t'(obs_v), row_t'(1));
        chk("whold_new_D", obs_im, d_row);

        // last row wraps to row 0, out-of-range row reads zero
        rd(1'b1, 1'b1, DEPTH - 1);
        rd(1'b1, 1'b1, DEPTH - 1);
        chk("wrap_hit", row_t'(obs_v), row_t'(1));
        rd(1'b1, 1'b0, 0);
        chk("wrap_row0", row_t'(obs_v), row_t'(PF));
        rd(1'b1, 1'b0, DEPTH);
        rd(1'b1, 1'b0, DEPTH);
        chk("oor_valid", row_t'(obs_v), row_t'(1));
        chk("oor_zero", obs_im | obs_neg | obs_pos, '0);

        // Req low keeps the buffer
        rd(1'b1, 1'b0, 5);
        rd(1'b1, 1'b0, 5);
        rd(1'b0, 1'b0, 5);
        chk("noreq_v", row_t'(obs_v), '0);
        rd(1'b1, 1'b0, 5);
        chk("noreq_retained", row_t'(obs_v), row_t'(1));

        // asynchronous reset mid-stream
        rd(1'b1, 1'b1, 12);
        rd(1'b1, 1'b1, 12);
        chk("pre_reset_v", row_t'(valid_so), row_t'(1));
        reset_ri = 1'b1;
        #1;
        chk("async_rst_v", row_t'(valid_so), '0);
        chk("async_rst_im", im_do, '0);
        chk("async_rst_ready", row_t'(ready_so), row_t'(1));
        @(posedge clk_ci);
        #1 reset_ri = 1'b0;
        held_a = -1; ahead_a = -1;
        rd(1'b1, 1'b0, 12);
        chk("post_rst_miss", row_t'(obs_v), '0);
        rd(1'b1, 1'b0, 12);
        chk("post_rst_hit", row_t'(obs_v), row_t'(1));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int ra, wa;
            logic we;
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH - 2, DEPTH + 3)
                                             : $urandom_range(0, 7);
            wa = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH - 1, DEPTH + 2)
                                             : $urandom_range(0, 7);
            we = ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), ra,
                 we, 2'($urandom_range(0, 3)), wa, rnd_row());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
